mmu_xlat_stage: RTL

- Two-stage virtual-to-physical translation pipe placed directly upstream of the TLB.
- Accepts virtual-address requests from the fetch/LSU, drives one TLB search port, and registers the TLB lookup result.
- Returns the physical address, cacheability and MIPS-style TLB exception class to the consumer over a valid/ready handshake.
- Handles unmapped kseg0/kseg1 segments locally; the TLB is not consulted for those.

---
 rtl/mmu_xlat_stage.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mmu_xlat_stage.sv
// Two-stage virtual-to-physical translation pipe in front of the TLB.
// Stage 1 holds the accepted request and drives the TLB search port;
// stage 2 registers the translated response for the consumer.
module mmu_xlat_stage #(
  parameter int unsigned TLBNUM = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_vaddr,
  input  logic                      req_wr,
  input  logic [7:0]                cur_asid,
  input  logic [2:0]                cfg_k0,
  output logic [18:0]               s_vpn2,
  output logic                      s_odd_page,
  output logic [7:0]                s_asid,
  input  logic                      s_found,
  input  logic [$clog2(TLBNUM)-1:0] s_index,
  input  logic [19:0]               s_pfn,
  input  logic [2:0]                s_c,
  input  logic                      s_d,
  input  logic                      s_v,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_paddr,
  output logic                      rsp_cached,
  output logic [1:0]                rsp_exc,
  output logic [31:0]               rsp_badvaddr,
  output logic [$clog2(TLBNUM)-1:0] rsp_index,
  output logic [15:0]               refill_cnt
);

  localparam int unsigned IDXW = $clog2(TLBNUM);
  localparam int unsigned CNTW = 16;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_REFILL  = 2'b01;
  localparam logic [1:0] EXC_INVALID = 2'b10;
  localparam logic [1:0] EXC_MOD     = 2'b11;

  localparam logic [2:0] CCA_CACHED = 3'd3;

  // Stage-1 request register
  logic            s1_valid_q, s1_valid_d;
  logic [31:0]     s1_vaddr_q, s1_vaddr_d;
  logic            s1_wr_q,    s1_wr_d;
  logic [7:0]      s1_asid_q,  s1_asid_d;

  // Stage-2 response register
  logic            rsp_valid_q,    rsp_valid_d;
  logic [31:0]     rsp_paddr_q,    rsp_paddr_d;
  logic            rsp_cached_q,   rsp_cached_d;
  logic [1:0]      rsp_exc_q,      rsp_exc_d;
  logic [31:0]     rsp_badvaddr_q, rsp_badvaddr_d;
  logic [IDXW-1:0] rsp_index_q,    rsp_index_d;

  logic [CNTW-1:0] refill_cnt_q, refill_cnt_d;

  // Translation of the stage-1 address
  logic [31:0]     xl_paddr;
  logic            xl_cached;
  logic [1:0]      xl_exc;
  logic [IDXW-1:0] xl_index;

  logic advance;
  logic req_fire;
  logic s1_fire;
  logic rsp_fire;

  // Handshake qualifiers; the response slot frees when it is empty or consumed
  always_comb begin
    advance   = !rsp_valid_q || rsp_ready;
    req_ready = !flush && !rst && (!s1_valid_q || advance);
    req_fire  = req_valid && req_ready;
    s1_fire   = s1_valid_q && advance;
    rsp_fire  = rsp_valid_q && rsp_ready && !flush;
  end

  // TLB search is driven straight from the stage-1 register
  always_comb begin
    s_vpn2     = s1_vaddr_q[31:13];
    s_odd_page = s1_vaddr_q[12];
    s_asid     = s1_asid_q;
  end

  // Translate: unmapped kseg0/kseg1 locally, otherwise use the TLB result
  always_comb begin
    xl_paddr  = 32'h0;
    xl_cached = 1'b0;
    xl_exc    = EXC_NONE;
    xl_index  = '0;
    if (s1_vaddr_q[31:30] == 2'b10) begin
      xl_paddr  = {3'b000, s1_vaddr_q[28:0]};
      xl_cached = !s1_vaddr_q[29] && (cfg_k0 == CCA_CACHED);
    end else if (!s_found) begin
      xl_exc = EXC_REFILL;
    end else begin
      xl_index = s_index;
      if (!s_v) begin
        xl_exc = EXC_INVALID;
      end else if (s1_wr_q && !s_d) begin
        xl_exc = EXC_MOD;
      end else begin
        xl_paddr  = {s_pfn, s1_vaddr_q[11:0]};
        xl_cached = (s_c == CCA_CACHED);
      end
    end
  end

  // Stage-1 next state: flush kills, acceptance loads, hand-off empties
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_vaddr_d = s1_vaddr_q;
    s1_wr_d    = s1_wr_q;
    s1_asid_d  = s1_asid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (req_fire) begin
      s1_valid_d = 1'b1;
      s1_vaddr_d = req_vaddr;
      s1_wr_d    = req_wr;
      s1_asid_d  = cur_asid;
    end else if (s1_fire) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage-2 next state: load on hand-off, drop once consumed, hold under backpressure
  always_comb begin
    rsp_valid_d    = rsp_valid_q;
    rsp_paddr_d    = rsp_paddr_q;
    rsp_cached_d   = rsp_cached_q;
    rsp_exc_d      = rsp_exc_q;
    rsp_badvaddr_d = rsp_badvaddr_q;
    rsp_index_d    = rsp_index_q;
    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (s1_fire) begin
      rsp_valid_d    = 1'b1;
      rsp_paddr_d    = xl_paddr;
      rsp_cached_d   = xl_cached;
      rsp_exc_d      = xl_exc;
      rsp_badvaddr_d = s1_vaddr_q;
      rsp_index_d    = xl_index;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Saturating count of refill exceptions handed to the consumer
  always_comb begin
    refill_cnt_d = refill_cnt_q;
    if (rsp_fire && (rsp_exc_q == EXC_REFILL) && (refill_cnt_q != {CNTW{1'b1}})) begin
      refill_cnt_d = refill_cnt_q + CNTW'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      s1_vaddr_q     <= 32'h0;
      s1_wr_q        <= 1'b0;
      s1_asid_q      <= 8'h0;
      rsp_valid_q    <= 1'b0;
      rsp_paddr_q    <= 32'h0;
      rsp_cached_q   <= 1'b0;
      rsp_exc_q      <= EXC_NONE;
      rsp_badvaddr_q <= 32'h0;
      rsp_index_q    <= '0;
      refill_cnt_q   <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_vaddr_q     <= s1_vaddr_d;
      s1_wr_q        <= s1_wr_d;
      s1_asid_q      <= s1_asid_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_paddr_q    <= rsp_paddr_d;
      rsp_cached_q   <= rsp_cached_d;
      rsp_exc_q      <= rsp_exc_d;
      rsp_badvaddr_q <= rsp_badvaddr_d;
      rsp_index_q    <= rsp_index_d;
      refill_cnt_q   <= refill_cnt_d;
    end
  end

  // Output ports
  always_comb begin
    rsp_valid    = rsp_valid_q;
    rsp_paddr    = rsp_paddr_q;
    rsp_cached   = rsp_cached_q;
    rsp_exc      = rsp_exc_q;
    rsp_badvaddr = rsp_badvaddr_q;
    rsp_index    = rsp_index_q;
    refill_cnt   = refill_cnt_q;
  end

endmodule
